mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: MAX_WAIT, 8'd15, number of cycles in WAIT without dm_ack_i before the access aborts.
REQ-002 cpu_clk_50M  input  1  sole clock; all state updates on its rising edge.
REQ-003 cpu_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 mem_aluop_i  input  8  operation code from the EX/MEM register; uses the `MINIMIPS32_* encodings in defines.v.
REQ-005 mem_wa_i / mem_wreg_i / mem_mreg_i  input  5/1/1  destination register, write enable, load-result flag.
REQ-006 mem_wd_i  input  32  ALU result; this is the effective address for loads and stores.
REQ-007 mem_din_i  input  32  store data.
REQ-008 mem_whilo_i / mem_hilo_i  input  1/64  HI/LO write enable and value, {HI,LO}.
REQ-009 dce_o  output  1  data-memory request.
REQ-010 daddr_o  output  32  word address, {mem_wd_i[31:2],2'b00}.
REQ-011 we_o  output  4  byte write strobes; all zero for loads.
REQ-012 din_o  output  32  write data.
REQ-013 dm_rdata_i / dm_ack_i  input  32/1  read data and request acknowledge.
REQ-014 mem_wa_o / mem_wreg_o / mem_dreg_o  output  5/1/32  writeback destination, enable and data.
REQ-015 mem_whilo_o / mem_hilo_o  output  1/64  HI/LO passed to writeback.
REQ-016 mem2id_wreg / mem2id_wa / mem2id_wd  output  1/5/32  register forwarding to ID.
REQ-017 mem2exe_whilo / mem2exe_hilo  output  1/64  HI/LO forwarding to EX.
REQ-018 stallreq_mem  output  1  pipeline stall request.
REQ-019 mem_exccode_o  output  5  exception code: 5'h1F none, 5'h04 ADEL, 5'h05 ADES, 5'h07 DBE.

Function
REQ-020 Memory ops SHALL be LB, LW, SB and SW; all other aluops SHALL pass through combinationally with dce_o=0 and stallreq_mem=0.
REQ-021 Alignment SHALL be checked first. LW with mem_wd_i[1:0]!=0 gives ADEL; SW with mem_wd_i[1:0]!=0 gives ADES. Either case SHALL issue no request, set mem_wreg_o=0 and mem_whilo_o=0, and raise no stall.
REQ-022 Byte lanes SHALL be little-endian. SB: we_o=4'b0001<<mem_wd_i[1:0], din_o={4{mem_din_i[7:0]}}. SW: we_o=4'hF, din_o=mem_din_i.
REQ-023 FSM states SHALL be IDLE, WAIT and DONE, with an 8-bit wait counter.
REQ-024 IDLE, valid memory op: dce_o=1 and stallreq_mem=1 (combinational). If dm_ack_i=1, go to DONE; otherwise go to WAIT with counter=0.
REQ-025 WAIT: dce_o=1 and stallreq_mem=1, with address, strobes and data held stable. On dm_ack_i go to DONE. Otherwise counter+1; when counter==MAX_WAIT-1, go to DONE with the abort flag set.
REQ-026 dm_ack_i in the timeout cycle SHALL win over the abort.
REQ-027 On ack, dm_rdata_i SHALL be captured into a 32-bit load buffer.
REQ-028 DONE: dce_o=0, stallreq_mem=0, next state IDLE, so the minimum load/store cost is one stall cycle.
REQ-029 DONE after abort: mem_exccode_o=DBE and mem_wreg_o=0.
REQ-030 LW result SHALL be the load buffer.
REQ-031 LB result SHALL be the sign-extended byte at buffer[8*addr[1:0]+7 : 8*addr[1:0]].
REQ-032 mem_dreg_o SHALL be the load result when mem_mreg_i=1, otherwise mem_wd_i.
REQ-033 Forwarding outputs SHALL equal the writeback outputs. ID relies on stallreq_mem while the load data is not valid.
REQ-034 mem2exe_whilo and mem2exe_hilo SHALL mirror mem_whilo_i and mem_hilo_i.

Reset
REQ-035 cpu_rst_n=0 SHALL immediately force the FSM to IDLE, counter and buffer to 0, all outputs to 0 and mem_exccode_o=5'h1F, including in the middle of WAIT.
REQ-036 The first request after reset release SHALL start from IDLE.

Verification
REQ-037 LW to 0x100 with ack in the same cycle -> one cycle with dce_o=1 and stall=1, then DONE with mem_dreg_o=dm_rdata_i=0xDEADBEEF and stall=0.
REQ-038 LB to 0x103 with rdata 0x80123456 -> mem_dreg_o=0xFFFFFF80.
REQ-039 SB to 0x102 with din 0x000000A5 -> we_o=4'b0100 and din_o=0xA5A5A5A5.
REQ-040 SW to 0x101 -> exccode 5'h05, dce_o=0, stall=0.
REQ-041 LW with no ack -> exactly MAX_WAIT WAIT cycles, then DBE with mem_wreg_o=0.
REQ-042 Ack in the final WAIT cycle -> normal completion. Reset asserted during WAIT -> dce_o=0 asynchronously.

Source files
------------

// File: rtl/mem_stage_if.sv
// ---------------------------------------------------------------------------
// mem_stage_if
// Data-memory bus between the MEM pipeline stage and the data memory.
//
// Signals
//   dce_o       stage -> memory  request strobe
//   daddr_o     stage -> memory  word-aligned byte address
//   we_o        stage -> memory  byte write strobes (zero for loads)
//   din_o       stage -> memory  write data, already placed in its byte lanes
//   dm_rdata_i  memory -> stage  read data (full word)
//   dm_ack_i    memory -> stage  request acknowledge
//
// Modports
//   master  the MEM stage
//   slave   the data memory
// ---------------------------------------------------------------------------
interface mem_stage_if;
    logic        dce_o;
    logic [31:0] daddr_o;
    logic [3:0]  we_o;
    logic [31:0] din_o;
    logic [31:0] dm_rdata_i;
    logic        dm_ack_i;

    modport master (
        output dce_o,
        output daddr_o,
        output we_o,
        output din_o,
        input  dm_rdata_i,
        input  dm_ack_i
    );

    modport slave (
        input  dce_o,
        input  daddr_o,
        input  we_o,
        input  din_o,
        output dm_rdata_i,
        output dm_ack_i
    );
endinterface

// File: rtl/mem_stage.sv
// ---------------------------------------------------------------------------
// mem_stage
// MEM stage of the MiniMIPS32 pipeline. Issues LB/LW/SB/SW to the data memory
// through a handshake (request, wait for ack, bounded by a timeout), checks
// word alignment, extracts load results and passes everything else through to
// writeback and the forwarding paths.
//
// Ports
//   cpu_clk_50M, cpu_rst_n          clock, async active-low reset
//   mem_aluop_i                     operation code from EX/MEM
//   mem_wa_i/mem_wreg_i/mem_mreg_i  destination, write enable, load flag
//   mem_wd_i                        ALU result / effective address
//   mem_din_i                       store data
//   mem_whilo_i/mem_hilo_i          HI/LO write enable and value {HI,LO}
//   dmem                            data-memory bus (master modport)
//   mem_wa_o/mem_wreg_o/mem_dreg_o  writeback destination, enable, data
//   mem_whilo_o/mem_hilo_o          HI/LO to writeback
//   mem2id_*                        register forwarding to ID
//   mem2exe_*                       HI/LO forwarding to EX
//   stallreq_mem                    stall request while an access is open
//   mem_exccode_o                   1F none, 04 ADEL, 05 ADES, 07 DBE
// ---------------------------------------------------------------------------
module mem_stage #(
    parameter logic [7:0] MAX_WAIT = 8'd15
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,

    input  logic [7:0]  mem_aluop_i,
    input  logic [4:0]  mem_wa_i,
    input  logic        mem_wreg_i,
    input  logic        mem_mreg_i,
    input  logic [31:0] mem_wd_i,
    input  logic [31:0] mem_din_i,
    input  logic        mem_whilo_i,
    input  logic [63:0] mem_hilo_i,

    mem_stage_if.master dmem,

    output logic [4:0]  mem_wa_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_dreg_o,
    output logic        mem_whilo_o,
    output logic [63:0] mem_hilo_o,

    output logic        mem2id_wreg,
    output logic [4:0]  mem2id_wa,
    output logic [31:0] mem2id_wd,

    output logic        mem2exe_whilo,
    output logic [63:0] mem2exe_hilo,

    output logic        stallreq_mem,
    output logic [4:0]  mem_exccode_o
);

    // MiniMIPS32 memory opcodes
    localparam logic [7:0] OP_LB = 8'h90;
    localparam logic [7:0] OP_LW = 8'h92;
    localparam logic [7:0] OP_SB = 8'h98;
    localparam logic [7:0] OP_SW = 8'h9A;

    localparam logic [4:0] EXC_NONE = 5'h1F;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_DBE  = 5'h07;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] lbuf_q, lbuf_d;
    logic        abort_q, abort_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  we_q, we_d;
    logic [31:0] wdat_q, wdat_d;

    logic        is_lb, is_lw, is_sb, is_sw, is_mem;
    logic        misaligned, req_ok;
    logic [31:0] issue_addr;
    logic [3:0]  issue_we;
    logic [31:0] issue_din;

    logic        dce, stall;
    logic [31:0] bus_addr, bus_din;
    logic [3:0]  bus_we;

    logic [31:0] shifted;
    logic [31:0] load_res;

    assign is_lb  = (mem_aluop_i == OP_LB);
    assign is_lw  = (mem_aluop_i == OP_LW);
    assign is_sb  = (mem_aluop_i == OP_SB);
    assign is_sw  = (mem_aluop_i == OP_SW);
    assign is_mem = is_lb | is_lw | is_sb | is_sw;

    // Only word accesses can be misaligned; a misaligned access never reaches the bus
    assign misaligned = (is_lw | is_sw) & (mem_wd_i[1:0] != 2'b00);
    assign req_ok     = is_mem & ~misaligned;

    assign issue_addr = {mem_wd_i[31:2], 2'b00};
    assign issue_we   = is_sb ? (4'b0001 << mem_wd_i[1:0]) : (is_sw ? 4'hF : 4'h0);
    assign issue_din  = is_sb ? {4{mem_din_i[7:0]}} : (is_sw ? mem_din_i : 32'h0);

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            lbuf_q  <= 32'd0;
            abort_q <= 1'b0;
            addr_q  <= 32'd0;
            we_q    <= 4'd0;
            wdat_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lbuf_q  <= lbuf_d;
            abort_q <= abort_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdat_q  <= wdat_d;
        end
    end

    // Request FSM. The bus fields are latched at issue so they stay frozen in
    // WAIT no matter what happens upstream. An ack in the timeout cycle is
    // checked before the timeout, so it completes normally.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        lbuf_d   = lbuf_q;
        abort_d  = abort_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdat_d   = wdat_q;
        dce      = 1'b0;
        stall    = 1'b0;
        bus_addr = 32'd0;
        bus_we   = 4'd0;
        bus_din  = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req_ok) begin
                    dce      = 1'b1;
                    stall    = 1'b1;
                    bus_addr = issue_addr;
                    bus_we   = issue_we;
                    bus_din  = issue_din;
                    addr_d   = issue_addr;
                    we_d     = issue_we;
                    wdat_d   = issue_din;
                    abort_d  = 1'b0;
                    if (dmem.dm_ack_i) begin
                        lbuf_d  = dmem.dm_rdata_i;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = 8'd0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                dce      = 1'b1;
                stall    = 1'b1;
                bus_addr = addr_q;
                bus_we   = we_q;
                bus_din  = wdat_q;
                if (dmem.dm_ack_i) begin
                    lbuf_d  = dmem.dm_rdata_i;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == MAX_WAIT - 8'd1) begin
                        abort_d = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte select for LB: shift the addressed byte down to bit 0
    assign shifted = lbuf_q >> {mem_wd_i[1:0], 3'b000};

    always_comb begin
        load_res = 32'd0;
        if (is_lw) begin
            load_res = lbuf_q;
        end else if (is_lb) begin
            load_res = {{24{shifted[7]}}, shifted[7:0]};
        end
    end

    // Writeback / forwarding. Exceptions suppress the register write; reset
    // forces every output to its idle value immediately, even mid-access.
    always_comb begin
        mem_wa_o      = mem_wa_i;
        mem_wreg_o    = mem_wreg_i;
        mem_dreg_o    = mem_mreg_i ? load_res : mem_wd_i;
        mem_whilo_o   = mem_whilo_i;
        mem_hilo_o    = mem_hilo_i;
        mem2exe_whilo = mem_whilo_i;
        mem2exe_hilo  = mem_hilo_i;
        stallreq_mem  = stall;
        mem_exccode_o = EXC_NONE;

        if (misaligned) begin
            mem_wreg_o    = 1'b0;
            mem_whilo_o   = 1'b0;
            mem_exccode_o = is_lw ? EXC_ADEL : EXC_ADES;
        end else if ((state_q == S_DONE) && abort_q) begin
            mem_wreg_o    = 1'b0;
            mem_exccode_o = EXC_DBE;
        end

        if (!cpu_rst_n) begin
            mem_wa_o      = 5'd0;
            mem_wreg_o    = 1'b0;
            mem_dreg_o    = 32'd0;
            mem_whilo_o   = 1'b0;
            mem_hilo_o    = 64'd0;
            mem2exe_whilo = 1'b0;
            mem2exe_hilo  = 64'd0;
            stallreq_mem  = 1'b0;
            mem_exccode_o = EXC_NONE;
        end
    end

    assign mem2id_wreg = mem_wreg_o;
    assign mem2id_wa   = mem_wa_o;
    assign mem2id_wd   = mem_dreg_o;

    assign dmem.dce_o   = dce & cpu_rst_n;
    assign dmem.daddr_o = cpu_rst_n ? bus_addr : 32'd0;
    assign dmem.we_o    = cpu_rst_n ? bus_we : 4'd0;
    assign dmem.din_o   = cpu_rst_n ? bus_din : 32'd0;

endmodule

// File: tb/tb_mem_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_stage
// Self-checking bench for mem_stage. Each scenario drives a transaction and
// compares the DUT against expectations computed from the access rules
// (alignment, byte lanes, ack latency vs. timeout, sign extension).
// ---------------------------------------------------------------------------
module tb_mem_stage;

    localparam logic [7:0] LB = 8'h90;
    localparam logic [7:0] LW = 8'h92;
    localparam logic [7:0] SB = 8'h98;
    localparam logic [7:0] SW = 8'h9A;
    localparam int         MAXW = 15;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  aluop;
    logic [4:0]  wa_i;
    logic        wreg_i, mreg_i;
    logic [31:0] wd_i, din_i;
    logic        whilo_i;
    logic [63:0] hilo_i;

    logic [4:0]  wa_o;
    logic        wreg_o;
    logic [31:0] dreg_o;
    logic        whilo_o;
    logic [63:0] hilo_o;
    logic        fw_wreg;
    logic [4:0]  fw_wa;
    logic [31:0] fw_wd;
    logic        fx_whilo;
    logic [63:0] fx_hilo;
    logic        stall;
    logic [4:0]  exc;

    int checks   = 0;
    int failures = 0;

    mem_stage_if dmem();

    mem_stage #(.MAX_WAIT(8'd15)) dut (
        .cpu_clk_50M   (clk),
        .cpu_rst_n     (rst_n),
        .mem_aluop_i   (aluop),
        .mem_wa_i      (wa_i),
        .mem_wreg_i    (wreg_i),
        .mem_mreg_i    (mreg_i),
        .mem_wd_i      (wd_i),
        .mem_din_i     (din_i),
        .mem_whilo_i   (whilo_i),
        .mem_hilo_i    (hilo_i),
        .dmem          (dmem),
        .mem_wa_o      (wa_o),
        .mem_wreg_o    (wreg_o),
        .mem_dreg_o    (dreg_o),
        .mem_whilo_o   (whilo_o),
        .mem_hilo_o    (hilo_o),
        .mem2id_wreg   (fw_wreg),
        .mem2id_wa     (fw_wa),
        .mem2id_wd     (fw_wd),
        .mem2exe_whilo (fx_whilo),
        .mem2exe_hilo  (fx_hilo),
        .stallreq_mem  (stall),
        .mem_exccode_o (exc)
    );

    always #5 clk = ~clk;

    // Safety net against a hung run
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // One memory transaction. ackDelay = request cycle (0 = issue cycle) in
    // which ack is given; anything beyond MAXW means no ack at all.
    task automatic do_mem(input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata,
                          input int ackDelay, input string name);
        logic        isLoad, isStore, mis, abort;
        logic [3:0]  expWe;
        logic [31:0] expDin, expAddr, expDreg, byteVal;
        logic [63:0] hv;
        logic [4:0]  wv;
        logic        hw;
        int          k;
        bit          fin;

        isLoad  = (op == LB) || (op == LW);
        isStore = (op == SB) || (op == SW);
        mis     = ((op == LW) || (op == SW)) && (addr[1:0] != 2'b00);
        abort   = (ackDelay > MAXW);
        expAddr = addr & 32'hFFFF_FFFC;
        expWe   = 4'h0;
        expDin  = 32'h0;
        if (op == SB) begin
            expWe  = 4'b0001 << addr[1:0];
            expDin = {4{sdata[7:0]}};
        end else if (op == SW) begin
            expWe  = 4'hF;
            expDin = sdata;
        end
        byteVal = (rdata >> (8 * addr[1:0])) & 32'hFF;
        if (op == LW)      expDreg = rdata;
        else if (op == LB) expDreg = byteVal[7] ? (byteVal | 32'hFFFF_FF00) : byteVal;
        else               expDreg = addr;

        wv = 5'($urandom_range(1, 31));
        hv = {$urandom(), $urandom()};
        hw = mis ? 1'b1 : 1'($urandom_range(0, 1));

        @(posedge clk); #1;
        aluop   = op;
        wd_i    = addr;
        din_i   = sdata;
        wa_i    = wv;
        wreg_i  = isLoad;
        mreg_i  = isLoad;
        whilo_i = hw;
        hilo_i  = hv;

        if (mis) begin
            dmem.dm_ack_i   = 1'b0;
            dmem.dm_rdata_i = $urandom();
            #3;
            checks++;
            if (dmem.dce_o !== 1'b0 || stall !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s misaligned dce/stall: got %b/%b want 0/0", name, dmem.dce_o, stall);
            end
            checks++;
            if (exc !== ((op == LW) ? 5'h04 : 5'h05) || wreg_o !== 1'b0 || whilo_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL %s misaligned exc/wreg/whilo: got %h/%b/%b want %h/0/0",
                         name, exc, wreg_o, whilo_o, (op == LW) ? 5'h04 : 5'h05);
            end
            return;
        end

        k   = 0;
        fin = 0;
        while (!fin) begin
            dmem.dm_ack_i   = (k == ackDelay);
            dmem.dm_rdata_i = (k == ackDelay) ? rdata : $urandom();
            #3;
            checks++;
            if (dmem.dce_o !== 1'b1 || stall !== 1'b1) begin
                failures++;
                $display("[TB] FAIL %s request cycle %0d dce/stall: got %b/%b want 1/1", name, k, dmem.dce_o, stall);
            end
            checks++;
            if (dmem.daddr_o !== expAddr || dmem.we_o !== expWe || (isStore && dmem.din_o !== expDin)) begin
                failures++;
                $display("[TB] FAIL %s request cycle %0d bus: got addr %h we %b din %h want addr %h we %b din %h",
                         name, k, dmem.daddr_o, dmem.we_o, dmem.din_o, expAddr, expWe, expDin);
            end
            fin = (k == ackDelay) || (k == MAXW);
            @(posedge clk); #1;
            k++;
        end

        // completion cycle
        dmem.dm_ack_i   = 1'b0;
        dmem.dm_rdata_i = $urandom();
        #3;
        checks++;
        if (dmem.dce_o !== 1'b0 || stall !== 1'b0) begin
            failures++;
            $display("[TB] FAIL %s done dce/stall: got %b/%b want 0/0", name, dmem.dce_o, stall);
        end
        checks++;
        if (exc !== (abort ? 5'h07 : 5'h1F) || wreg_o !== (abort ? 1'b0 : isLoad)
            || fw_wreg !== (abort ? 1'b0 : isLoad)) begin
            failures++;
            $display("[TB] FAIL %s done exc/wreg/fwd: got %h/%b/%b want %h/%b", name, exc, wreg_o, fw_wreg,
                     abort ? 5'h07 : 5'h1F, abort ? 1'b0 : isLoad);
        end
        if (!abort) begin
            checks++;
            if (dreg_o !== expDreg || fw_wd !== expDreg || wa_o !== wv || fw_wa !== wv) begin
                failures++;
                $display("[TB] FAIL %s done data: got dreg %h fwd %h wa %0d want dreg %h wa %0d",
                         name, dreg_o, fw_wd, wa_o, expDreg, wv);
            end
        end
        checks++;
        if (whilo_o !== hw || hilo_o !== hv || fx_whilo !== hw || fx_hilo !== hv) begin
            failures++;
            $display("[TB] FAIL %s done hilo: got %b/%h want %b/%h", name, whilo_o, hilo_o, hw, hv);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        aluop   = LW;
        wd_i    = 32'h0000_0100;
        din_i   = 32'h1234_5678;
        wa_i    = 5'd3;
        wreg_i  = 1'b1;
        mreg_i  = 1'b1;
        whilo_i = 1'b1;
        hilo_i  = 64'hAAAA_5555_1234_8765;
        dmem.dm_ack_i   = 1'b0;
        dmem.dm_rdata_i = 32'h0;
        #12;
        checks++;
        if (dmem.dce_o !== 1'b0 || stall !== 1'b0 || exc !== 5'h1F) begin
            failures++;
            $display("[TB] FAIL reset dce/stall/exc: got %b/%b/%h want 0/0/1f", dmem.dce_o, stall, exc);
        end
        checks++;
        if (wreg_o !== 1'b0 || dreg_o !== 32'h0 || fx_whilo !== 1'b0 || fx_hilo !== 64'h0 || whilo_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset outputs: got wreg %b dreg %h fx_whilo %b fx_hilo %h",
                     wreg_o, dreg_o, fx_whilo, fx_hilo);
        end
        aluop = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        do_mem(LW, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0, "lw_ack0");
        do_mem(LB, 32'h0000_0103, 32'h0, 32'h8012_3456, 0, "lb_signext");
        do_mem(LB, 32'h0000_0101, 32'h0, 32'h8012_3456, 3, "lb_positive");
        do_mem(SB, 32'h0000_0102, 32'h0000_00A5, 32'h0, 1, "sb_lane2");
        do_mem(SW, 32'h0000_0101, 32'h1111_2222, 32'h0, 0, "sw_misaligned");
        do_mem(LW, 32'h0000_0202, 32'h0, 32'h0, 0, "lw_misaligned");
        do_mem(SW, 32'h0000_0400, 32'hCAFE_F00D, 32'h0, 2, "sw_aligned");
    endtask

    task automatic test_timeout();
        do_mem(LW, 32'h0000_0300, 32'h0, 32'h5A5A_5A5A, MAXW + 1, "lw_timeout");
        do_mem(LW, 32'h0000_0304, 32'h0, 32'h0BAD_F00D, MAXW, "lw_ack_last");
        do_mem(SW, 32'h0000_0308, 32'h7777_8888, 32'h0, MAXW - 1, "sw_ack_late");
    endtask

    task automatic test_reset_in_wait();
        @(posedge clk); #1;
        aluop   = LW;
        wd_i    = 32'h0000_0200;
        wreg_i  = 1'b1;
        mreg_i  = 1'b1;
        dmem.dm_ack_i = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #1;
        checks++;
        if (dmem.dce_o !== 1'b1 || stall !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_wait pre dce/stall: got %b/%b want 1/1", dmem.dce_o, stall);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dmem.dce_o !== 1'b0 || stall !== 1'b0 || exc !== 5'h1F || wreg_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_wait async: got dce %b stall %b exc %h wreg %b want 0/0/1f/0",
                     dmem.dce_o, stall, exc, wreg_o);
        end
        aluop = 8'h00;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_mem(LW, 32'h0000_0500, 32'h0, 32'h0, MAXW + 2, "post_rst_timeout");
        do_mem(LW, 32'h0000_0504, 32'h0, 32'h1357_9BDF, 1, "post_rst_lw");
    endtask

    task automatic test_passthrough(input int n);
        logic [7:0]  ops [4];
        logic [31:0] wv;
        logic [63:0] hv;
        logic [4:0]  av;
        logic        rv, hw;
        ops[0] = 8'h18; ops[1] = 8'h1C; ops[2] = 8'h00; ops[3] = 8'h2A;
        for (int i = 0; i < n; i++) begin
            wv = $urandom();
            hv = {$urandom(), $urandom()};
            av = 5'($urandom_range(0, 31));
            rv = 1'($urandom_range(0, 1));
            hw = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            aluop   = ops[$urandom_range(0, 3)];
            wd_i    = wv;
            din_i   = $urandom();
            wa_i    = av;
            wreg_i  = rv;
            mreg_i  = 1'b0;
            whilo_i = hw;
            hilo_i  = hv;
            dmem.dm_ack_i = 1'b0;
            #3;
            checks++;
            if (dmem.dce_o !== 1'b0 || stall !== 1'b0 || exc !== 5'h1F) begin
                failures++;
                $display("[TB] FAIL pass %0d dce/stall/exc: got %b/%b/%h want 0/0/1f", i, dmem.dce_o, stall, exc);
            end
            checks++;
            if (wa_o !== av || wreg_o !== rv || dreg_o !== wv || fw_wa !== av || fw_wreg !== rv || fw_wd !== wv) begin
                failures++;
                $display("[TB] FAIL pass %0d wb: got wa %0d wreg %b dreg %h want %0d %b %h",
                         i, wa_o, wreg_o, dreg_o, av, rv, wv);
            end
            checks++;
            if (whilo_o !== hw || hilo_o !== hv || fx_whilo !== hw || fx_hilo !== hv) begin
                failures++;
                $display("[TB] FAIL pass %0d hilo: got %b/%h want %b/%h", i, whilo_o, hilo_o, hw, hv);
            end
        end
    endtask

    task automatic test_random(input int n);
        logic [7:0]  ops [4];
        logic [31:0] addr;
        ops[0] = LB; ops[1] = LW; ops[2] = SB; ops[3] = SW;
        for (int i = 0; i < n; i++) begin
            addr = $urandom();
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            do_mem(ops[$urandom_range(0, 3)], addr, $urandom(), $urandom(),
                   $urandom_range(0, MAXW + 2), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_passthrough(6);
        test_reset_in_wait();
        test_random(40);
        test_passthrough(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
